// File: rtl/rv_mem_pkg.sv
// Shared definitions for the memory-access stage.
//   - RV32 load/store func_3 width/sign codes
//   - load/store unit FSM state encoding
//   - data-memory byte-enable width
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ma_state_e;

endpackage

// File: rtl/ma_load_align.sv
// Load alignment / extension (purely combinational).
// Picks the addressed byte or half out of a 32-bit read word and sign- or
// zero-extends it according to the RV32 load func_3 code.
// Ports:
//   rdata  in  32  word returned by data memory
//   offset in  2   byte offset within the word (address[1:0])
//   func_3 in  3   load width/sign code
//   ext    out 32  extended load result
module ma_load_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  func_3,
    output logic [31:0] ext
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // Halves are picked by offset[1] only; a misaligned half truncates.
    assign sel_b = rdata[{offset, 3'b000} +: 8];
    assign sel_h = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ext = rdata;
        case (func_3)
            F3_B:    ext = {{24{sel_b[7]}}, sel_b};
            F3_BU:   ext = {24'h0, sel_b};
            F3_H:    ext = {{16{sel_h[15]}}, sel_h};
            F3_HU:   ext = {16'h0, sel_h};
            F3_W:    ext = rdata;
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/ma_load_store_unit.sv
// Memory-access stage load/store unit.
// Turns an EX/MA load or store into one req/ack transaction on the data
// memory port, steers store bytes onto the right lanes, extends load data,
// and stalls the pipeline with BUSYWAIT while the access is in flight.
// Optional build macro MA_MISALIGN_TRAP_EN: adds misalign_exc and refuses
// misaligned half/word accesses instead of truncating the offset.
// Ports:
//   CLK, RESET             clock, synchronous active-high reset
//   mem_read, mem_write    access request (both high = store)
//   func_3                 width/sign code
//   address, store_data    byte address, store operand
//   BUSYWAIT               combinational pipeline stall
//   load_data, load_valid  registered load result and its one-cycle strobe
//   dmem_*                 registered request side of the memory port
//   dmem_rdata, dmem_ack   memory response
//   misalign_exc           (MA_MISALIGN_TRAP_EN only) misaligned-access pulse
module ma_load_store_unit
    import rv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            func_3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           store_data,
    output logic                  BUSYWAIT,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [BE_W-1:0]       dmem_be,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_ack
`ifdef MA_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_exc
`endif
);

    if (DATA_WIDTH != 32) begin : g_dw_check
        $error("ma_load_store_unit: DATA_WIDTH must be 32");
    end

    ma_state_e         state, state_next;
    logic              req;
    logic              trap;
    logic [1:0]        off;
    logic [BE_W-1:0]   st_be;
    logic [31:0]       st_wdata;
    logic [2:0]        ld_f3;
    logic [1:0]        ld_off;
    logic [31:0]       ld_ext;

    assign req = mem_read | mem_write;
    assign off = address[1:0];

    // Store lane steering; loads always fetch the whole word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        case (func_3)
            F3_B: begin
                st_be    = 4'b0001 << off;
                st_wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                st_be    = off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MA_MISALIGN_TRAP_EN
    // Width class comes from func_3[1:0] for loads (bit 2 is only the sign),
    // but stores treat every code other than SB/SH as a word.
    always_comb begin
        trap = 1'b0;
        if (mem_write) begin
            case (func_3)
                F3_B:    trap = 1'b0;
                F3_H:    trap = off[0];
                default: trap = (off != 2'b00);
            endcase
        end else begin
            case (func_3[1:0])
                2'b00:   trap = 1'b0;
                2'b01:   trap = off[0];
                default: trap = (off != 2'b00);
            endcase
        end
    end
`else
    assign trap = 1'b0;
`endif

    ma_load_align u_align (
        .rdata  (dmem_rdata),
        .offset (ld_off),
        .func_3 (ld_f3),
        .ext    (ld_ext)
    );

    always_comb begin
        state_next = state;
        BUSYWAIT   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    BUSYWAIT   = 1'b1;
                    state_next = trap ? DONE : WAIT;
                end
            end
            WAIT: begin
                BUSYWAIT = 1'b1;
                if (dmem_ack) state_next = DONE;
            end
            // EX/MA advances at the end of DONE, so its stale request is ignored.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            ld_f3      <= '0;
            ld_off     <= '0;
`ifdef MA_MISALIGN_TRAP_EN
            misalign_exc <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            load_valid <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
            misalign_exc <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        if (trap) begin
`ifdef MA_MISALIGN_TRAP_EN
                            misalign_exc <= 1'b1;
`endif
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {address[ADDR_WIDTH-1:2], 2'b00};
                            dmem_be    <= mem_write ? st_be : 4'b1111;
                            dmem_wdata <= mem_write ? st_wdata : 32'h0;
                            ld_f3      <= func_3;
                            ld_off     <= off;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            load_data  <= ld_ext;
                            load_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
